// File: rtl/bist_controller.sv
// -----------------------------------------------------------------------------
// bist_controller
//
// Sequencing FSM for the chip-level BIST datapath (TPG -> CUT -> MISR).
// Seeds the TPG, resets the CUT, applies NUM_PATTERNS patterns, keeps the
// MISR compacting for LATENCY extra cycles so the last CUT response is
// captured, then compares the signature against GOLDEN_SIG.
//
// Optional feature macro: BIST_SIG_OBS_EN
//   When defined, adds sig_obs_o, which captures misr_sig_i in the COMPARE
//   cycle and holds it through DONE (used to harvest GOLDEN_SIG).
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous, active-high reset
//   bistmode_i   1 = BIST requested, 0 = functional mode
//   misr_sig_i   current MISR contents
//   pi_sel_o     1 = CUT PIs from TPG, 0 = from chip pins
//   cut_rst_o    synchronous reset to CUT flops
//   tpg_load_o   load TPG seed this cycle
//   tpg_en_o     advance TPG this cycle
//   misr_clear_o clear MISR this cycle
//   misr_en_o    compact CUT PO into MISR this cycle
//   sig_obs_o    captured signature (BIST_SIG_OBS_EN only)
//   bistdone_o   run complete, held until bistmode_i drops
//   bistpass_o   signature matched, valid while bistdone_o = 1
//
// States:
//   IDLE    | functional mode, waiting for bistmode_i
//   INIT    | seed TPG, reset CUT, clear MISR (1 cycle)
//   RUN     | apply NUM_PATTERNS patterns
//   FLUSH   | keep compacting for LATENCY cycles after the last pattern
//   COMPARE | sample signature against GOLDEN_SIG (1 cycle)
//   DONE    | report result until bistmode_i drops
// -----------------------------------------------------------------------------
module bist_controller #(
    parameter int                NUM_PATTERNS = 2000,
    parameter int                LATENCY      = 1,
    parameter int                SIG_W        = 49,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG   = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bistmode_i,
    input  logic [SIG_W-1:0] misr_sig_i,
    output logic             pi_sel_o,
    output logic             cut_rst_o,
    output logic             tpg_load_o,
    output logic             tpg_en_o,
    output logic             misr_clear_o,
    output logic             misr_en_o,
`ifdef BIST_SIG_OBS_EN
    output logic [SIG_W-1:0] sig_obs_o,
`endif
    output logic             bistdone_o,
    output logic             bistpass_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam logic [15:0] N_M1   = 16'(NUM_PATTERNS - 1);
    localparam logic [15:0] LAT16  = 16'(LATENCY);
    localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    // The flush counter counts down from LATENCY-1. Global cycle index within
    // RUN+FLUSH is NUM_PATTERNS + (LATENCY-1-flush_cnt); compaction is wanted
    // only for index >= LATENCY, i.e. flush_cnt <= NUM_PATTERNS-1. This keeps
    // misr_en at exactly NUM_PATTERNS cycles even when NUM_PATTERNS < LATENCY.
    localparam logic MISR_FLUSH_FIRST = ({12'd0, LAT_M1} <= N_M1);

    state_e      state_q;
    logic [15:0] pat_cnt_q;
    logic [3:0]  flush_cnt_q;
    logic        pi_sel_q;
    logic        cut_rst_q;
    logic        tpg_load_q;
    logic        tpg_en_q;
    logic        misr_clear_q;
    logic        misr_en_q;
    logic        bistdone_q;
    logic        bistpass_q;
`ifdef BIST_SIG_OBS_EN
    logic [SIG_W-1:0] sig_obs_q;
`endif

    logic [15:0] pat_cnt_d;
    logic [3:0]  flush_cnt_d;
    logic        misr_run_d;
    logic        misr_flush_d;
    logic        sig_match;

    assign pat_cnt_d    = pat_cnt_q + 16'd1;
    assign flush_cnt_d  = flush_cnt_q - 4'd1;
    assign misr_run_d   = (pat_cnt_d >= LAT16);
    assign misr_flush_d = ({12'd0, flush_cnt_d} <= N_M1);
    assign sig_match    = (misr_sig_i == GOLDEN_SIG);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pat_cnt_q    <= 16'd0;
            flush_cnt_q  <= 4'd0;
            pi_sel_q     <= 1'b0;
            cut_rst_q    <= 1'b0;
            tpg_load_q   <= 1'b0;
            tpg_en_q     <= 1'b0;
            misr_clear_q <= 1'b0;
            misr_en_q    <= 1'b0;
            bistdone_q   <= 1'b0;
            bistpass_q   <= 1'b0;
`ifdef BIST_SIG_OBS_EN
            sig_obs_q    <= '0;
`endif
        end else begin
            // Single-cycle strobes default low; outputs are registered for
            // the state being entered.
            cut_rst_q    <= 1'b0;
            tpg_load_q   <= 1'b0;
            tpg_en_q     <= 1'b0;
            misr_clear_q <= 1'b0;
            misr_en_q    <= 1'b0;

            if (!bistmode_i) begin
                // Abort from any active state, or release from DONE.
                state_q    <= S_IDLE;
                pi_sel_q   <= 1'b0;
                bistdone_q <= 1'b0;
                bistpass_q <= 1'b0;
`ifdef BIST_SIG_OBS_EN
                sig_obs_q  <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q      <= S_INIT;
                        pi_sel_q     <= 1'b1;
                        cut_rst_q    <= 1'b1;
                        tpg_load_q   <= 1'b1;
                        misr_clear_q <= 1'b1;
                        pat_cnt_q    <= 16'd0;
                    end
                    S_INIT: begin
                        state_q   <= S_RUN;
                        pat_cnt_q <= 16'd0;
                        tpg_en_q  <= 1'b1;
                        misr_en_q <= (LATENCY == 0);
                    end
                    S_RUN: begin
                        if (pat_cnt_q == N_M1) begin
                            if (LATENCY > 0) begin
                                state_q     <= S_FLUSH;
                                flush_cnt_q <= LAT_M1;
                                misr_en_q   <= MISR_FLUSH_FIRST;
                            end else begin
                                state_q <= S_COMPARE;
                            end
                        end else begin
                            pat_cnt_q <= pat_cnt_d;
                            tpg_en_q  <= 1'b1;
                            misr_en_q <= misr_run_d;
                        end
                    end
                    S_FLUSH: begin
                        if (flush_cnt_q == 4'd0) begin
                            state_q <= S_COMPARE;
                        end else begin
                            flush_cnt_q <= flush_cnt_d;
                            misr_en_q   <= misr_flush_d;
                        end
                    end
                    S_COMPARE: begin
                        state_q    <= S_DONE;
                        bistdone_q <= 1'b1;
                        bistpass_q <= sig_match;
`ifdef BIST_SIG_OBS_EN
                        sig_obs_q  <= misr_sig_i;
`endif
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        pi_sel_q   <= 1'b0;
                        bistdone_q <= 1'b0;
                        bistpass_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pi_sel_o     = pi_sel_q;
    assign cut_rst_o    = cut_rst_q;
    assign tpg_load_o   = tpg_load_q;
    assign tpg_en_o     = tpg_en_q;
    assign misr_clear_o = misr_clear_q;
    assign misr_en_o    = misr_en_q;
    assign bistdone_o   = bistdone_q;
    assign bistpass_o   = bistpass_q;
`ifdef BIST_SIG_OBS_EN
    assign sig_obs_o    = sig_obs_q;
`endif

endmodule

// File: tb/tb_bist_controller.sv
module tb_bist_controller;

    localparam logic [48:0] GOLD = 49'h1234;
    localparam logic [48:0] BAD  = 49'h1235;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: NUM_PATTERNS=8, LATENCY=2
    logic        a_rst = 1'b1, a_bm = 1'b1;
    logic [48:0] a_sig = GOLD;
    logic a_pi_sel, a_cut_rst, a_tpg_load, a_tpg_en, a_misr_clear, a_misr_en, a_bistdone, a_bistpass;
    logic [7:0] a_out;
    assign a_out = {a_pi_sel, a_cut_rst, a_tpg_load, a_tpg_en, a_misr_clear, a_misr_en, a_bistdone, a_bistpass};

    // DUT B: NUM_PATTERNS=8, LATENCY=0
    logic        b_rst = 1'b1, b_bm = 1'b0;
    logic [48:0] b_sig = GOLD;
    logic b_pi_sel, b_cut_rst, b_tpg_load, b_tpg_en, b_misr_clear, b_misr_en, b_bistdone, b_bistpass;
    logic [7:0] b_out;
    assign b_out = {b_pi_sel, b_cut_rst, b_tpg_load, b_tpg_en, b_misr_clear, b_misr_en, b_bistdone, b_bistpass};

    // DUT C: NUM_PATTERNS=1, LATENCY=3 (fewer patterns than latency)
    logic        c_rst = 1'b1, c_bm = 1'b0;
    logic [48:0] c_sig = GOLD;
    logic c_pi_sel, c_cut_rst, c_tpg_load, c_tpg_en, c_misr_clear, c_misr_en, c_bistdone, c_bistpass;

`ifdef BIST_SIG_OBS_EN
    logic [48:0] a_sig_obs, b_sig_obs, c_sig_obs;
`endif

    bist_controller #(.NUM_PATTERNS(8), .LATENCY(2), .SIG_W(49), .GOLDEN_SIG(GOLD)) u_a (
        .clk_i(clk), .rst_i(a_rst), .bistmode_i(a_bm), .misr_sig_i(a_sig),
        .pi_sel_o(a_pi_sel), .cut_rst_o(a_cut_rst), .tpg_load_o(a_tpg_load), .tpg_en_o(a_tpg_en),
        .misr_clear_o(a_misr_clear), .misr_en_o(a_misr_en),
`ifdef BIST_SIG_OBS_EN
        .sig_obs_o(a_sig_obs),
`endif
        .bistdone_o(a_bistdone), .bistpass_o(a_bistpass));

    bist_controller #(.NUM_PATTERNS(8), .LATENCY(0), .SIG_W(49), .GOLDEN_SIG(GOLD)) u_b (
        .clk_i(clk), .rst_i(b_rst), .bistmode_i(b_bm), .misr_sig_i(b_sig),
        .pi_sel_o(b_pi_sel), .cut_rst_o(b_cut_rst), .tpg_load_o(b_tpg_load), .tpg_en_o(b_tpg_en),
        .misr_clear_o(b_misr_clear), .misr_en_o(b_misr_en),
`ifdef BIST_SIG_OBS_EN
        .sig_obs_o(b_sig_obs),
`endif
        .bistdone_o(b_bistdone), .bistpass_o(b_bistpass));

    bist_controller #(.NUM_PATTERNS(1), .LATENCY(3), .SIG_W(49), .GOLDEN_SIG(GOLD)) u_c (
        .clk_i(clk), .rst_i(c_rst), .bistmode_i(c_bm), .misr_sig_i(c_sig),
        .pi_sel_o(c_pi_sel), .cut_rst_o(c_cut_rst), .tpg_load_o(c_tpg_load), .tpg_en_o(c_tpg_en),
        .misr_clear_o(c_misr_clear), .misr_en_o(c_misr_en),
`ifdef BIST_SIG_OBS_EN
        .sig_obs_o(c_sig_obs),
`endif
        .bistdone_o(c_bistdone), .bistpass_o(c_bistpass));

    typedef struct {
        logic        rst;
        logic        bm;
        logic [48:0] sig;
        logic [7:0]  exp; // {pi_sel,cut_rst,tpg_load,tpg_en,misr_clear,misr_en,bistdone,bistpass}
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic rst, input logic bm, input logic [48:0] sig, input logic [7:0] exp);
        vec_t v;
        v.rst = rst; v.bm = bm; v.sig = sig; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Full run on DUT A from IDLE with bistmode held high: INIT, 8 RUN
    // (misr_en from the 3rd), 2 FLUSH, COMPARE, DONE.
    task automatic add_run(input logic [48:0] sig, input logic pass);
        add(1'b0, 1'b1, sig, 8'b1110_1000);
        repeat (2) add(1'b0, 1'b1, sig, 8'b1001_0000);
        repeat (6) add(1'b0, 1'b1, sig, 8'b1001_0100);
        repeat (2) add(1'b0, 1'b1, sig, 8'b1000_0100);
        add(1'b0, 1'b1, sig, 8'b1000_0000);
        add(1'b0, 1'b1, sig, {7'b1000_001, pass});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int n, edges, ten, men, mism;

    initial begin
        // Table: reset, fault-free run, hold, release, faulty run, abort in FLUSH.
        add(1'b1, 1'b1, GOLD, 8'b0000_0000);
        add_run(GOLD, 1'b1);
        add(1'b0, 1'b1, GOLD, 8'b1000_0011);
        add(1'b0, 1'b0, GOLD, 8'b0000_0000);
        add_run(BAD, 1'b0);
        add(1'b0, 1'b0, BAD, 8'b0000_0000);
        add(1'b0, 1'b1, GOLD, 8'b1110_1000);
        repeat (2) add(1'b0, 1'b1, GOLD, 8'b1001_0000);
        repeat (6) add(1'b0, 1'b1, GOLD, 8'b1001_0100);
        add(1'b0, 1'b1, GOLD, 8'b1000_0100);
        add(1'b0, 1'b0, GOLD, 8'b0000_0000);
        add(1'b0, 1'b0, GOLD, 8'b0000_0000);

        foreach (vecs[i]) begin
            a_rst = vecs[i].rst;
            a_bm  = vecs[i].bm;
            a_sig = vecs[i].sig;
            step();
            chk($sformatf("vec%0d", i), {56'd0, a_out}, {56'd0, vecs[i].exp});
`ifdef BIST_SIG_OBS_EN
            chk($sformatf("vec%0d_sig_obs", i), {15'd0, a_sig_obs},
                {15'd0, (vecs[i].exp[1] ? vecs[i].sig : 49'd0)});
`endif
        end

        // Reset mid-RUN after 4 tpg_en cycles, then a complete fresh run.
        a_sig = GOLD;
        a_bm  = 1'b1;
        step();
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            step();
            if (a_tpg_en) n++;
        end
        chk("midrun_tpg_en_before_rst", n, 4);
        a_rst = 1'b1;
        step();
        chk("midrun_rst_outputs", {56'd0, a_out}, 64'd0);
        a_rst = 1'b0;
        step();
        chk("restart_init", {56'd0, a_out}, {56'd0, 8'b1110_1000});
        edges = 1; ten = 0; men = 0;
        while (!a_bistdone && edges < 40) begin
            step();
            edges++;
            ten += int'(a_tpg_en);
            men += int'(a_misr_en);
        end
        chk("restart_done_edge", edges, 13);
        chk("restart_tpg_en_cycles", ten, 8);
        chk("restart_misr_en_cycles", men, 8);
        chk("restart_bistpass", {63'd0, a_bistpass}, 64'd1);
`ifdef BIST_SIG_OBS_EN
        chk("restart_sig_obs", {15'd0, a_sig_obs}, {15'd0, GOLD});
`endif
        a_bm = 1'b0;
        step();
        chk("release_outputs", {56'd0, a_out}, 64'd0);
`ifdef BIST_SIG_OBS_EN
        chk("release_sig_obs", {15'd0, a_sig_obs}, 64'd0);
`endif

        // LATENCY=0: misr_en tracks tpg_en, DONE at the 11th edge.
        step();
        b_rst = 1'b0;
        chk("lat0_reset_outputs", {56'd0, b_out}, 64'd0);
        b_bm = 1'b1;
        edges = 0; ten = 0; mism = 0;
        while (!b_bistdone && edges < 40) begin
            step();
            edges++;
            ten += int'(b_tpg_en);
            if (b_tpg_en !== b_misr_en) mism++;
        end
        chk("lat0_done_edge", edges, 11);
        chk("lat0_tpg_en_cycles", ten, 8);
        chk("lat0_misr_tpg_mismatch", mism, 0);
        chk("lat0_bistpass", {63'd0, b_bistpass}, 64'd1);

        // NUM_PATTERNS=1 < LATENCY=3: misr_en still exactly one cycle.
        c_rst = 1'b0;
        c_bm  = 1'b1;
        edges = 0; ten = 0; men = 0;
        while (!c_bistdone && edges < 40) begin
            step();
            edges++;
            ten += int'(c_tpg_en);
            men += int'(c_misr_en);
        end
        chk("n1_done_edge", edges, 7);
        chk("n1_tpg_en_cycles", ten, 1);
        chk("n1_misr_en_cycles", men, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
